fetch_prefetch_unit: RTL

//  Parametrised instruction-fetch front end for the multicycle RISC-V core.

---
 rtl/fetch_prefetch_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited requests,
// buffers in-order responses in a prefetch queue and flushes it on redirect.
module fetch_prefetch_unit #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            Clk,
    input  logic            Reset,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [ILEN-1:0] mem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_pc,
    output logic [ILEN-1:0] instr_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    localparam int unsigned     CW         = $clog2(DEPTH + 1);
    localparam int unsigned     PW         = $clog2(DEPTH);
    localparam logic [CW:0]     DEPTH_W    = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] RESET_PC_A = {RESET_PC[XLEN-1:2], 2'b00};

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    ptr_t            wr_ptr_q, wr_ptr_d;
    ptr_t            rd_ptr_q, rd_ptr_d;
    cnt_t            occ_q, occ_d;
    cnt_t            outst_q, outst_d;
    cnt_t            drop_q, drop_d;

    logic [XLEN-1:0] qpc_q   [DEPTH];
    logic [ILEN-1:0] qdata_q [DEPTH];

    logic            issue;
    logic            push;
    logic            pop;
    logic [CW:0]     in_use;
    logic [XLEN-1:0] redirect_pc_a;
    logic            unused_redirect_lsb;

    assign redirect_pc_a       = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Queued plus in-flight entries may never exceed DEPTH, so a push always has room.
    assign in_use        = {1'b0, occ_q} + {1'b0, outst_q};
    assign mem_req_valid = Reset && !redirect_valid && (in_use < DEPTH_W);
    assign mem_req_addr  = fetch_pc_q;
    assign issue         = mem_req_valid && mem_req_ready;

    assign instr_valid   = Reset && (occ_q != '0);
    assign instr_pc      = instr_valid ? qpc_q[rd_ptr_q]   : '0;
    assign instr_data    = instr_valid ? qdata_q[rd_ptr_q] : '0;
    assign busy          = Reset && (outst_q != '0);

    assign pop  = instr_valid && instr_ready && !redirect_valid;
    assign push = Reset && mem_rsp_valid && (drop_q == '0) && !redirect_valid;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        drop_d     = drop_q;
        outst_d    = outst_q + cnt_t'(issue) - cnt_t'(mem_rsp_valid);

        if (issue) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end

        if (redirect_valid) begin
            // Every request still in flight after this edge must be discarded on return.
            fetch_pc_d = redirect_pc_a;
            rsp_pc_d   = redirect_pc_a;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            occ_d      = '0;
            drop_d     = outst_q - cnt_t'(mem_rsp_valid);
        end else begin
            if (mem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - cnt_t'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
                rsp_pc_d = rsp_pc_q + PC_STEP;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            occ_d = occ_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            fetch_pc_q <= RESET_PC_A;
            rsp_pc_q   <= RESET_PC_A;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            qpc_q[wr_ptr_q]   <= rsp_pc_q;
            qdata_q[wr_ptr_q] <= mem_rsp_data;
        end
    end

    a_rsp_has_credit: assert property (@(posedge Clk) disable iff (!Reset)
        mem_rsp_valid |-> (outst_q != '0));

endmodule
